// File: rtl/uart_line_proc.sv
// uart_line_proc: line editor between the uart RX FIFO and TX FIFO.
// Pops received bytes into a line buffer (backspace removes the last byte,
// LF is ignored), and on the terminator writes the buffered line back to the
// TX FIFO, optionally upper-cased, followed by CR LF.
//
// Handshake: a byte is taken from the RX FIFO by a one-cycle rd_uart pulse
// while rx_empty=0 (r_data is the FIFO head, first-word-fall-through); a byte
// is given to the TX FIFO by a one-cycle wr_uart pulse that is only issued
// when tx_full=0 was seen on the deciding edge, and every push is followed by
// a dead cycle so tx_full can reflect it before the next decision.
module uart_line_proc #(
    parameter int         DEPTH = 32,
    parameter logic [7:0] TERM  = 8'h0D,
    parameter bit         UPPER = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rx_empty,
    input  logic [7:0]               r_data,
    output logic                     rd_uart,
    input  logic                     tx_full,
    output logic [7:0]               w_data,
    output logic                     wr_uart,
    output logic [$clog2(DEPTH):0]   line_len,
    output logic                     overflow,
    output logic                     busy,
    output logic [7:0]               line_count,
    output logic [2:0]               state_dbg
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam int AW = $clog2(DEPTH);
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_BS = 8'h08;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PROC    = 3'd1,
        TX_DATA = 3'd2,
        TX_WAIT = 3'd3,
        TX_CR   = 3'd4,
        TX_LF   = 3'd5
    } state_t;

    state_t          state_q;
    logic [7:0]      rx_byte_q;
    logic [LW-1:0]   line_len_q;
    logic [LW-1:0]   tx_len_q;
    logic [LW-1:0]   tx_idx_q;
    logic            cr_sent_q;   // TX_WAIT after the CR push leads to TX_LF
    logic            rd_q;
    logic            wr_q;
    logic [7:0]      w_data_q;
    logic            overflow_q;
    logic            busy_q;
    logic [7:0]      line_count_q;

    logic [7:0]      mem [DEPTH];

    logic            is_term;
    logic            is_lf;
    logic            is_bs;
    logic            room;
    logic            store_en;
    logic [7:0]      tx_byte;

    function automatic logic [7:0] conv(input logic [7:0] b);
        if (UPPER && (b >= 8'h61) && (b <= 8'h7A)) begin
            return b - 8'h20;
        end
        return b;
    endfunction

    // Classify the byte under processing and form the transmit byte.
    always_comb begin
        is_term  = (rx_byte_q == TERM);
        is_lf    = !is_term && (rx_byte_q == CH_LF);
        is_bs    = !is_term && !is_lf && (rx_byte_q == CH_BS);
        room     = (line_len_q < DEPTH_L);
        store_en = (state_q == PROC) && !is_term && !is_lf && !is_bs && room;
        tx_byte  = conv(mem[tx_idx_q[AW-1:0]]);
    end

    // Line buffer storage; contents are irrelevant after reset.
    always_ff @(posedge clk) begin
        if (store_en) begin
            mem[line_len_q[AW-1:0]] <= rx_byte_q;
        end
    end

    // Main FSM with registered strobes and status.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            rx_byte_q    <= 8'h00;
            line_len_q   <= '0;
            tx_len_q     <= '0;
            tx_idx_q     <= '0;
            cr_sent_q    <= 1'b0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            w_data_q     <= 8'h00;
            overflow_q   <= 1'b0;
            busy_q       <= 1'b0;
            line_count_q <= 8'h00;
        end else begin
            rd_q <= 1'b0;
            wr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!rx_empty) begin
                        rx_byte_q <= r_data;
                        rd_q      <= 1'b1;
                        state_q   <= PROC;
                    end
                end
                PROC: begin
                    if (is_term) begin
                        tx_len_q  <= line_len_q;
                        tx_idx_q  <= '0;
                        busy_q    <= 1'b1;
                        cr_sent_q <= 1'b0;
                        state_q   <= (line_len_q == '0) ? TX_CR : TX_DATA;
                    end else if (is_lf) begin
                        state_q <= IDLE;
                    end else if (is_bs) begin
                        if (line_len_q != '0) begin
                            line_len_q <= line_len_q - 1'b1;
                        end
                        state_q <= IDLE;
                    end else begin
                        if (room) begin
                            line_len_q <= line_len_q + 1'b1;
                        end else begin
                            overflow_q <= 1'b1;
                        end
                        state_q <= IDLE;
                    end
                end
                TX_DATA: begin
                    if (!tx_full) begin
                        w_data_q <= tx_byte;
                        wr_q     <= 1'b1;
                        tx_idx_q <= tx_idx_q + 1'b1;
                        state_q  <= TX_WAIT;
                    end
                end
                TX_WAIT: begin
                    if (cr_sent_q) begin
                        state_q <= TX_LF;
                    end else if (tx_idx_q < tx_len_q) begin
                        state_q <= TX_DATA;
                    end else begin
                        state_q <= TX_CR;
                    end
                end
                TX_CR: begin
                    if (!tx_full) begin
                        w_data_q  <= CH_CR;
                        wr_q      <= 1'b1;
                        cr_sent_q <= 1'b1;
                        state_q   <= TX_WAIT;
                    end
                end
                TX_LF: begin
                    if (!tx_full) begin
                        w_data_q     <= CH_LF;
                        wr_q         <= 1'b1;
                        cr_sent_q    <= 1'b0;
                        line_len_q   <= '0;
                        overflow_q   <= 1'b0;
                        busy_q       <= 1'b0;
                        line_count_q <= line_count_q + 8'd1;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rd_uart    = rd_q;
    assign wr_uart    = wr_q;
    assign w_data     = w_data_q;
    assign line_len   = line_len_q;
    assign overflow   = overflow_q;
    assign busy       = busy_q;
    assign line_count = line_count_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_uart_line_proc.sv
// Directed bench for uart_line_proc (DEPTH=4, CR terminator, upper-casing).
// Models the RX FIFO as a byte queue and scoreboards TX pushes against exp_q.
module tb_uart_line_proc;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_empty = 1'b1;
    logic [7:0] r_data = 8'h00;
    logic       rd_uart;
    logic       tx_full;
    logic [7:0] w_data;
    logic       wr_uart;
    logic [2:0] line_len;
    logic       overflow;
    logic       busy;
    logic [7:0] line_count;
    logic [2:0] state_dbg;

    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int push_cnt = 0;
    int cyc      = 0;
    int last_push = 0;
    bit have_last = 1'b0;

    // Clock
    always #5 clk = ~clk;

    uart_line_proc #(.DEPTH(DEPTH), .TERM(8'h0D), .UPPER(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_empty   (rx_empty),
        .r_data     (r_data),
        .rd_uart    (rd_uart),
        .tx_full    (tx_full),
        .w_data     (w_data),
        .wr_uart    (wr_uart),
        .line_len   (line_len),
        .overflow   (overflow),
        .busy       (busy),
        .line_count (line_count),
        .state_dbg  (state_dbg)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // RX FIFO head presented away from the sampling edge
    always @(negedge clk) begin
        rx_empty = (rx_q.size() == 0);
        r_data   = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
    end

    // RX FIFO pop on the strobe
    always @(posedge clk) begin
        if (!reset && rd_uart) begin
            check("pop_nonempty", rx_q.size() != 0, 1);
            check("pop_not_busy", busy, 0);
            if (rx_q.size() != 0) void'(rx_q.pop_front());
        end
    end

    // TX scoreboard
    always @(posedge clk) begin
        cyc++;
        if (!reset && wr_uart) begin
            push_cnt++;
            check("push_not_full", tx_full, 0);
            if (have_last) check("push_gap_ge2", (cyc - last_push) >= 2, 1);
            last_push = cyc;
            have_last = 1'b1;
            check("push_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("tx_byte", w_data, exp_q.pop_front());
        end
    end

    task automatic send_byte(input logic [7:0] b);
        rx_q.push_back(b);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) rx_q.push_back(s[i]);
    endtask

    task automatic expect_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    task automatic expect_crlf();
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic wait_idle(input string tag);
        bit done = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            if (rx_q.size() == 0 && state_dbg == 3'd0 && !rd_uart && !busy && !wr_uart)
                done = 1'b1;
        end
        check({tag, "_idle_timeout"}, done, 1);
    endtask

    initial begin
        int snap;
        bit done;

        // Reset
        reset   = 1'b1;
        tx_full = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_line_len", line_len, 0);
        check("rst_overflow", overflow, 0);
        check("rst_busy", busy, 0);
        check("rst_line_count", line_count, 0);
        check("rst_wr_uart", wr_uart, 0);
        check("rst_rd_uart", rd_uart, 0);
        check("rst_w_data", w_data, 0);
        check("rst_state", state_dbg, 0);

        // "hola" CR -> HOLA CR LF
        expect_str("HOLA"); expect_crlf();
        send_str("hola"); send_byte(8'h0D);
        wait_idle("hola");
        check("hola_exp_left", exp_q.size(), 0);
        check("hola_line_count", line_count, 1);
        check("hola_line_len", line_len, 0);
        check("hola_busy", busy, 0);

        // Backspace editing
        expect_str("AC"); expect_crlf();
        send_str("AB"); send_byte(8'h08); send_str("C"); send_byte(8'h0D);
        wait_idle("bs");
        check("bs_exp_left", exp_q.size(), 0);
        check("bs_line_count", line_count, 2);

        // Backspace on empty line
        snap = push_cnt;
        send_byte(8'h08);
        wait_idle("bs_empty");
        check("bs_empty_line_len", line_len, 0);
        check("bs_empty_no_push", push_cnt, snap);

        // Overflow with DEPTH=4
        send_str("ABCD");
        wait_idle("ovf_fill");
        check("ovf_full_len", line_len, 4);
        check("ovf_before_e", overflow, 0);
        send_str("E");
        wait_idle("ovf_e");
        check("ovf_after_e", overflow, 1);
        check("ovf_len_held", line_len, 4);
        expect_str("ABCD"); expect_crlf();
        send_str("F"); send_byte(8'h0D);
        wait_idle("ovf_tx");
        check("ovf_exp_left", exp_q.size(), 0);
        check("ovf_cleared", overflow, 0);
        check("ovf_line_len", line_len, 0);
        check("ovf_line_count", line_count, 3);

        // Lone CR, then LF CR
        snap = push_cnt;
        expect_crlf(); expect_crlf();
        send_byte(8'h0D);
        wait_idle("lone_cr");
        send_byte(8'h0A); send_byte(8'h0D);
        wait_idle("lf_cr");
        check("empty_lines_exp_left", exp_q.size(), 0);
        check("empty_lines_pushes", push_cnt - snap, 4);
        check("empty_lines_count", line_count, 5);

        // Backpressure stall mid-line, RX held off while busy
        snap = push_cnt;
        expect_str("ABCD"); expect_crlf();
        send_str("abcd"); send_byte(8'h0D);
        done = 1'b0;
        for (int i = 0; i < 500 && !done; i++) begin
            @(negedge clk);
            if (push_cnt - snap >= 2) done = 1'b1;
        end
        check("stall_reach_timeout", done, 1);
        tx_full = 1'b1;
        repeat (2) @(negedge clk);
        snap = push_cnt;
        send_str("z");
        repeat (50) @(negedge clk);
        check("stall_no_push", push_cnt, snap);
        check("stall_rx_held", rx_q.size(), 1);
        check("stall_busy", busy, 1);
        tx_full = 1'b0;
        wait_idle("stall");
        check("stall_exp_left", exp_q.size(), 0);
        check("stall_line_count", line_count, 6);
        check("stall_z_buffered", line_len, 1);
        expect_str("Z"); expect_crlf();
        send_byte(8'h0D);
        wait_idle("z_line");
        check("z_exp_left", exp_q.size(), 0);
        check("z_line_count", line_count, 7);

        // Asynchronous reset during TX_DATA
        tx_full = 1'b1;
        send_str("ABCD"); send_byte(8'h0D);
        done = 1'b0;
        for (int i = 0; i < 500 && !done; i++) begin
            @(negedge clk);
            if (state_dbg == 3'd2) done = 1'b1;
        end
        check("rst_tx_reach_timeout", done, 1);
        check("rst_tx_busy_before", busy, 1);
        #2 reset = 1'b1;
        #1;
        check("arst_wr_uart", wr_uart, 0);
        check("arst_busy", busy, 0);
        check("arst_line_len", line_len, 0);
        check("arst_line_count", line_count, 0);
        check("arst_state", state_dbg, 0);
        @(negedge clk);
        reset   = 1'b0;
        tx_full = 1'b0;
        expect_str("X"); expect_crlf();
        send_str("X"); send_byte(8'h0D);
        wait_idle("post_rst");
        check("post_rst_exp_left", exp_q.size(), 0);
        check("post_rst_line_count", line_count, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
